fwft_fifo: RTL and testbench
============================

FWFT_FIFO -- requirements
Module: fwft_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the payload width in bits.
REQ-002 Parameter ADDR_WIDTH, default 4, SHALL set DEPTH = 2**ADDR_WIDTH; capacity is exactly DEPTH words (no lost slot).
REQ-003 Parameter AF_THRESH, default DEPTH-2, SHALL set the almost_full level (count >= AF_THRESH).
REQ-004 Parameter AE_THRESH, default 2, SHALL set the almost_empty level (count <= AE_THRESH).
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 flush  input  1  synchronous clear of all contents.
REQ-008 in_data  input  DATA_WIDTH  write payload.
REQ-009 in_valid  input  1  write request.
REQ-010 in_ready  output  1  space available; a write is accepted on an edge where in_valid && in_ready.
REQ-011 out_data  output  DATA_WIDTH  head-of-queue word, valid while out_valid=1.
REQ-012 out_valid  output  1  out_data holds a word.
REQ-013 out_ready  input  1  consumer accepts; a pop occurs on an edge where out_valid && out_ready.
REQ-014 count  output  ADDR_WIDTH+1  words held, including the output stage, range 0..DEPTH.
REQ-015 almost_full, almost_empty  output  1 each  threshold flags per REQ-003/004, decoded from the count register.
REQ-016 overflow, underflow  output  1 each  sticky error flags (present only per REQ-032).

Function
REQ-017 Storage SHALL be a DEPTH-entry array with a registered read port plus one output-stage register (first-word-fall-through).
REQ-018 Pointers SHALL be ADDR_WIDTH+1 bits; the MSB distinguishes full from empty on wrap-around; index = low ADDR_WIDTH bits.
REQ-019 in_ready SHALL equal (count < DEPTH), driven from registers only, with no combinational path from out_ready.
REQ-020 Into an empty FIFO, a word accepted at edge k SHALL appear with out_valid=1 after edge k+2.
REQ-021 While out_valid=1 and out_ready=0, out_data and out_valid SHALL hold stable.
REQ-022 After a pop with further words queued, the next word SHALL be presented with no bubble cycle (sustained 1 word/cycle throughput).
REQ-023 Words SHALL leave in strict acceptance order.
REQ-024 count SHALL update on the edge: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-025 At count=DEPTH, a push with a simultaneous pop SHALL be rejected (in_ready=0); count becomes DEPTH-1.
REQ-026 A pop is impossible while out_valid=0; out_ready is ignored in that state.
REQ-027 flush=1 SHALL, on the next edge, zero the pointers and count and clear out_valid; any push or pop in that cycle SHALL be discarded; error flags SHALL be unaffected.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for clk, clear the pointers, count and out_valid, set in_ready=1 and almost_empty=1, and clear almost_full, overflow and underflow.
REQ-029 Array contents SHALL NOT be reset; out_data is don't-care while out_valid=0.
REQ-030 Reset asserted mid-transfer SHALL drop all queued words; after release, the first accepted word is the first delivered.

Configuration
REQ-031 Macro FIFO_ERR_FLAGS_EN SHALL compile in the overflow/underflow logic.
REQ-032 With FIFO_ERR_FLAGS_EN defined: overflow SHALL set on an edge with in_valid=1 && in_ready=0; underflow SHALL set on an edge with out_ready=1 && out_valid=0; both SHALL clear only on reset. Without the macro, both ports SHALL be tied to 0 and carry no registers.

Verification
REQ-033 Reset; push 0x11 at edge 1 -> out_valid=1 and out_data=0x11 after edge 3; count=1; almost_empty=1.
REQ-034 Defaults: push 16 words 0x00..0x0F with out_ready=0 -> count=16, in_ready=0, almost_full=1 from count=14; then pop all -> data 0x00..0x0F in order, back-to-back.
REQ-035 Full FIFO with in_valid=1 and out_ready=1 together -> no push, one pop, count=15; with FIFO_ERR_FLAGS_EN, overflow=1 and held.
REQ-036 Continuous push and pop for 40 cycles (pointer wrap) -> zero loss or reordering, count stable, out_valid never drops after the first word.
REQ-037 count=5, then flush=1 for one cycle -> count=0, out_valid=0, in_ready=1 next cycle; out_ready=1 on the empty FIFO sets underflow=1 (macro on) or leaves it 0 (macro off).
REQ-038 rst_n pulsed low between edges with count=7 -> count=0 and out_valid=0 before the next edge.

Source files
------------

// File: rtl/fwft_fifo.sv
// First-word-fall-through FIFO: DEPTH-entry array with a registered read port feeding one output register.
// Define FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags; otherwise both ports are tied to 0.
module fwft_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
   parameter int AE_THRESH  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
   localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);
   localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic [DATA_WIDTH-1:0] out_data_q;

   logic push, pop, mem_nonempty, rd_load, out_load;

   always_comb begin
      push         = in_valid && in_ready;
      pop          = out_valid_q && out_ready;
      mem_nonempty = (wr_ptr_q != rd_ptr_q);
      // Refill the output register when it empties or pops; refill the read stage behind it the same way.
      out_load     = rd_valid_q && (!out_valid_q || pop);
      rd_load      = mem_nonempty && (!rd_valid_q || out_load);

      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      rd_valid_d  = rd_valid_q;
      out_valid_d = out_valid_q;

      if (flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         rd_valid_d  = 1'b0;
         out_valid_d = 1'b0;
      end else begin
         if (push)    wr_ptr_d = wr_ptr_q + ONE_C;
         if (rd_load) rd_ptr_d = rd_ptr_q + ONE_C;
         if (rd_load)       rd_valid_d = 1'b1;
         else if (out_load) rd_valid_d = 1'b0;
         if (out_load) out_valid_d = 1'b1;
         else if (pop) out_valid_d = 1'b0;
         if (push && !pop)      count_d = count_q + ONE_C;
         else if (!push && pop) count_d = count_q - ONE_C;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         rd_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         rd_valid_q  <= rd_valid_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Payload path carries no reset; validity is tracked solely by the flags above.
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= in_data;
      if (rd_load)        rd_data_q <= mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
      if (out_load)       out_data_q <= rd_data_q;
   end

   assign in_ready     = (count_q < DEPTH_C);
   assign out_data     = out_data_q;
   assign out_valid    = out_valid_q;
   assign count        = count_q;
   assign almost_full  = (count_q >= AF_C);
   assign almost_empty = (count_q <= AE_C);

`ifdef FIFO_ERR_FLAGS_EN
   logic overflow_q, underflow_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (in_valid && !in_ready)    overflow_q  <= 1'b1;
         if (out_ready && !out_valid_q) underflow_q <= 1'b1;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fwft_fifo.sv
// Directed bench for fwft_fifo: latency, fill/drain order, full-with-pop, streaming wrap, flush and async reset.
module tb_fwft_fifo;

  localparam int DW = 8;
  localparam int AW = 4;
`ifdef FIFO_ERR_FLAGS_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW:0]   count;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];

  fwft_fifo dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bit seen_valid;
    rst_n = 1'b0; flush = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    step(); step();
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_ae", almost_empty, 1);
    check("rst_af", almost_full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_unf", underflow, 0);
    rst_n = 1'b1;

    // single word latency: accepted at edge 1, visible after edge 3
    in_valid = 1'b1; in_data = 8'h11;
    step();
    in_valid = 1'b0;
    check("lat_e1_count", count, 1);
    check("lat_e1_valid", out_valid, 0);
    step();
    check("lat_e2_valid", out_valid, 0);
    step();
    check("lat_e3_valid", out_valid, 1);
    check("lat_e3_data", out_data, 8'h11);
    check("lat_e3_count", count, 1);
    check("lat_e3_ae", almost_empty, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("lat_pop_count", count, 0);
    check("lat_pop_valid", out_valid, 0);

    // fill 16 with no consumer
    for (int i = 0; i < 16; i++) begin
      check("fill_in_ready", in_ready, 1);
      in_valid = 1'b1; in_data = DW'(i);
      step();
      check("fill_count", count, i + 1);
      check("fill_af", almost_full, (i + 1 >= 14) ? 1 : 0);
    end
    in_valid = 1'b0;
    check("full_in_ready", in_ready, 0);
    check("full_count", count, 16);
    check("full_head", out_data, 8'h00);

    // full with simultaneous push attempt and pop
    in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("fullpop_count", count, 15);
    check("fullpop_in_ready", in_ready, 1);
    check("fullpop_ovf", overflow, ERR);
    for (int i = 1; i < 16; i++) begin
      check("drain_valid", out_valid, 1);
      check("drain_data", out_data, i);
      step();
      check("drain_count", count, 15 - i);
    end
    out_ready = 1'b0;
    check("drain_end_valid", out_valid, 0);
    step();
    check("drain_rejected_absent", out_valid, 0);
    check("ovf_held", overflow, ERR);
    check("unf_clear", underflow, 0);

    // continuous push and pop across pointer wrap
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1; in_data = DW'(8'h40 + i);
      check("stream_in_ready", in_ready, 1);
      if (out_valid && out_ready) begin
        check("stream_data", out_data, exp_q[0]);
        void'(exp_q.pop_front());
      end
      exp_q.push_back(in_data);
      step();
      check("stream_count", count, exp_q.size());
      if (seen_valid) check("stream_no_bubble", out_valid, 1);
      if (out_valid) seen_valid = 1'b1;
      out_ready = seen_valid;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin
        check("stream_drain_data", out_data, exp_q[0]);
        void'(exp_q.pop_front());
      end
      step();
      if (!out_valid) break;
    end
    out_ready = 1'b0;
    check("stream_model_empty", exp_q.size(), 0);
    check("stream_final_count", count, 0);
    check("stream_unf", underflow, 0);

    // flush with count=5, a push in the flush cycle is discarded
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = DW'(8'h80 + i);
      step();
    end
    check("preflush_count", count, 5);
    flush = 1'b1; in_data = 8'hEE;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_count", count, 0);
    check("flush_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    check("flush_ovf_kept", overflow, ERR);
    step(); step();
    check("flush_discard_count", count, 0);
    check("flush_discard_valid", out_valid, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("unf_on_empty", underflow, ERR);
    check("unf_count", count, 0);
    in_valid = 1'b1; in_data = 8'h77;
    step();
    in_valid = 1'b0;
    step(); step();
    check("postflush_valid", out_valid, 1);
    check("postflush_data", out_data, 8'h77);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // async reset between edges with count=7
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_data = DW'(8'h30 + i);
      step();
    end
    in_valid = 1'b0;
    check("prereset_count", count, 7);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_count", count, 0);
    check("async_rst_valid", out_valid, 0);
    check("async_rst_in_ready", in_ready, 1);
    check("async_rst_ovf", overflow, 0);
    check("async_rst_unf", underflow, 0);
    #2 rst_n = 1'b1;
    in_valid = 1'b1; in_data = 8'h5A;
    step();
    in_valid = 1'b0;
    step(); step();
    check("post_rst_valid", out_valid, 1);
    check("post_rst_data", out_data, 8'h5A);
    check("post_rst_count", count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
